// File: rtl/prefetch_data_queue.sv
//------------------------------------------------------------------------------
// Module      : prefetch_data_queue
// Description : Ordered ring buffer of prefetched read blocks; executes the
//               prefetcher controller's opcode stream and returns promised
//               blocks in order.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prefetch_data_queue #(
    parameter int ADDR_BITS            = 64,
    parameter int LOG_QUEUE_SIZE       = 3,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    localparam int BLOCK_BITS          = 8 * (2 ** LOG_BLOCK_DATA_BYTES),
    localparam int PW                  = LOG_QUEUE_SIZE + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  dataFlushN,
    input  logic [2:0]            pr_opCode,
    input  logic [ADDR_BITS-1:0]  pr_addr,
    input  logic [BLOCK_BITS-1:0] pr_r_out_data,
    input  logic                  pr_r_out_last,
    output logic                  pr_r_valid,
    output logic [BLOCK_BITS-1:0] pr_r_data,
    output logic                  pr_r_last,
    output logic                  pr_addrHit,
    output logic                  pr_hasOutstanding,
    output logic [PW-1:0]         prefetchReqCnt,
    output logic                  almostFull,
    output logic                  protErr
);

    localparam int      DEPTH       = 1 << LOG_QUEUE_SIZE;
    localparam logic [PW-1:0] c_depth   = PW'(DEPTH);
    localparam logic [PW-1:0] c_depth_m1 = PW'(DEPTH - 1);

    localparam logic [2:0] c_op_nop     = 3'd0;
    localparam logic [2:0] c_op_pref    = 3'd1;
    localparam logic [2:0] c_op_master  = 3'd2;
    localparam logic [2:0] c_op_data    = 3'd3;
    localparam logic [2:0] c_op_promise = 3'd4;

    logic [ADDR_BITS-1:0]  r_addr     [DEPTH];
    logic [BLOCK_BITS-1:0] r_data     [DEPTH];
    logic                  r_last     [DEPTH];
    logic                  r_dval     [DEPTH];
    logic                  r_promised [DEPTH];

    // Pointers carry one extra MSB so full (occupancy == DEPTH) differs from empty
    logic [PW-1:0] r_head, r_prom, r_fill, r_tail;
    logic          r_prot_err;

    logic [LOG_QUEUE_SIZE-1:0] w_head_idx, w_prom_idx, w_fill_idx, w_tail_idx;
    logic [PW-1:0]             w_occ;
    logic                      w_full, w_hit, w_head_ready;

    assign w_head_idx = r_head[LOG_QUEUE_SIZE-1:0];
    assign w_prom_idx = r_prom[LOG_QUEUE_SIZE-1:0];
    assign w_fill_idx = r_fill[LOG_QUEUE_SIZE-1:0];
    assign w_tail_idx = r_tail[LOG_QUEUE_SIZE-1:0];

    assign w_occ        = r_tail - r_head;
    assign w_full       = (w_occ == c_depth);
    assign w_hit        = (r_prom != r_tail) && (r_addr[w_prom_idx] == pr_addr);
    assign w_head_ready = (r_head != r_prom) && r_dval[w_head_idx] && r_promised[w_head_idx];

    assign pr_r_valid        = w_head_ready;
    assign pr_r_data         = r_data[w_head_idx];
    assign pr_r_last         = r_last[w_head_idx];
    assign pr_addrHit        = en && (pr_opCode == c_op_master) && w_hit;
    assign pr_hasOutstanding = (r_fill != r_tail);
    assign prefetchReqCnt    = r_tail - r_prom;
    assign almostFull        = (w_occ >= c_depth_m1);
    assign protErr           = r_prot_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_prom     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_prot_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]     <= '0;
                r_data[i]     <= '0;
                r_last[i]     <= 1'b0;
                r_dval[i]     <= 1'b0;
                r_promised[i] <= 1'b0;
            end
        end else if (en) begin
            if (!dataFlushN) begin
                // Flush drops every entry; stored addr/data stay but are unreachable
                r_head     <= '0;
                r_prom     <= '0;
                r_fill     <= '0;
                r_tail     <= '0;
                r_prot_err <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_dval[i]     <= 1'b0;
                    r_promised[i] <= 1'b0;
                end
            end else begin
                case (pr_opCode)
                    c_op_nop: ;
                    c_op_pref: begin
                        if (!w_full) begin
                            r_addr[w_tail_idx]     <= pr_addr;
                            r_dval[w_tail_idx]     <= 1'b0;
                            r_promised[w_tail_idx] <= 1'b0;
                            r_tail                 <= r_tail + 1'b1;
                        end else begin
                            r_prot_err <= 1'b1;
                        end
                    end
                    c_op_master: begin
                        // A miss is a normal outcome, not a protocol error
                        if (w_hit) begin
                            r_promised[w_prom_idx] <= 1'b1;
                            r_prom                 <= r_prom + 1'b1;
                        end
                    end
                    c_op_data: begin
                        if (r_fill != r_tail) begin
                            r_data[w_fill_idx] <= pr_r_out_data;
                            r_last[w_fill_idx] <= pr_r_out_last;
                            r_dval[w_fill_idx] <= 1'b1;
                            r_fill             <= r_fill + 1'b1;
                        end else begin
                            r_prot_err <= 1'b1;
                        end
                    end
                    c_op_promise: begin
                        if (w_head_ready) begin
                            r_head <= r_head + 1'b1;
                        end else begin
                            r_prot_err <= 1'b1;
                        end
                    end
                    default: r_prot_err <= 1'b1;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prefetch_data_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_prefetch_data_queue
// Description : Directed self-checking bench for prefetch_data_queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prefetch_data_queue;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         dataFlushN;
    logic [2:0]   pr_opCode;
    logic [63:0]  pr_addr;
    logic [511:0] pr_r_out_data;
    logic         pr_r_out_last;
    logic         pr_r_valid;
    logic [511:0] pr_r_data;
    logic         pr_r_last;
    logic         pr_addrHit;
    logic         pr_hasOutstanding;
    logic [3:0]   prefetchReqCnt;
    logic         almostFull;
    logic         protErr;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0]  c_a  = 64'h0000_0000_0000_1000;
    localparam logic [63:0]  c_b  = 64'h0000_0000_0008_0000;
    localparam logic [511:0] c_d0 = {16{32'hD0D0_1234}};
    localparam logic [511:0] c_d1 = {16{32'hD1D1_5678}};

    always #5 clk = ~clk;

    prefetch_data_queue dut (
        .clk               (clk),
        .reset             (reset),
        .en                (en),
        .dataFlushN        (dataFlushN),
        .pr_opCode         (pr_opCode),
        .pr_addr           (pr_addr),
        .pr_r_out_data     (pr_r_out_data),
        .pr_r_out_last     (pr_r_out_last),
        .pr_r_valid        (pr_r_valid),
        .pr_r_data         (pr_r_data),
        .pr_r_last         (pr_r_last),
        .pr_addrHit        (pr_addrHit),
        .pr_hasOutstanding (pr_hasOutstanding),
        .prefetchReqCnt    (prefetchReqCnt),
        .almostFull        (almostFull),
        .protErr           (protErr)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one opcode for one rising edge; outputs settle 1 time unit later
    task automatic op(input logic [2:0] c, input logic [63:0] a, input logic [511:0] d,
                      input logic l);
        pr_opCode = c; pr_addr = a; pr_r_out_data = d; pr_r_out_last = l;
        @(posedge clk); #1;
        pr_opCode = 3'd0;
    endtask

    task automatic master_req(input logic [63:0] a, input logic exp_hit);
        pr_opCode = 3'd2; pr_addr = a;
        #1;
        chk("addr_hit", 512'(pr_addrHit), 512'(exp_hit));
        @(posedge clk); #1;
        pr_opCode = 3'd0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; dataFlushN = 1'b1;
        pr_opCode = 3'd0; pr_addr = '0; pr_r_out_data = '0; pr_r_out_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_valid",  512'(pr_r_valid), 512'(0));
        chk("rst_cnt",    512'(prefetchReqCnt), 512'(0));
        chk("rst_outst",  512'(pr_hasOutstanding), 512'(0));
        chk("rst_afull",  512'(almostFull), 512'(0));
        chk("rst_perr",   512'(protErr), 512'(0));
        chk("rst_data",   pr_r_data, 512'(0));

        op(3'd1, c_a, '0, 1'b0);
        op(3'd1, c_a + 64'h40, '0, 1'b0);
        op(3'd1, c_a + 64'h80, '0, 1'b0);
        chk("alloc3_cnt",   512'(prefetchReqCnt), 512'(3));
        chk("alloc3_outst", 512'(pr_hasOutstanding), 512'(1));
        chk("alloc3_afull", 512'(almostFull), 512'(0));
        chk("alloc3_valid", 512'(pr_r_valid), 512'(0));

        op(3'd3, '0, c_d0, 1'b1);
        master_req(c_a, 1'b1);
        chk("prom_valid", 512'(pr_r_valid), 512'(1));
        chk("prom_data",  pr_r_data, c_d0);
        chk("prom_last",  512'(pr_r_last), 512'(1));
        chk("prom_cnt",   512'(prefetchReqCnt), 512'(2));
        op(3'd4, '0, '0, 1'b0);
        chk("pop_valid",  512'(pr_r_valid), 512'(0));

        master_req(c_a + 64'h80, 1'b0);
        chk("miss_cnt",  512'(prefetchReqCnt), 512'(2));
        chk("miss_perr", 512'(protErr), 512'(0));

        // Pop with an unpromised head is a protocol error
        op(3'd4, '0, '0, 1'b0);
        chk("badpop_perr",  512'(protErr), 512'(1));
        chk("badpop_cnt",   512'(prefetchReqCnt), 512'(2));

        en = 1'b0;
        pr_opCode = 3'd1; pr_addr = c_a; #1;
        chk("en0_hit", 512'(pr_addrHit), 512'(0));
        @(posedge clk); #1; pr_opCode = 3'd0;
        chk("en0_cnt", 512'(prefetchReqCnt), 512'(2));
        en = 1'b1;

        op(3'd3, '0, c_d1, 1'b0);
        op(3'd3, '0, c_d1, 1'b0);
        chk("filled_outst", 512'(pr_hasOutstanding), 512'(0));
        op(3'd3, '0, c_d1, 1'b0);
        chk("drop_perr", 512'(protErr), 512'(1));

        dataFlushN = 1'b0;
        op(3'd1, c_b, '0, 1'b0);
        dataFlushN = 1'b1;
        chk("flush_cnt",   512'(prefetchReqCnt), 512'(0));
        chk("flush_perr",  512'(protErr), 512'(0));
        chk("flush_outst", 512'(pr_hasOutstanding), 512'(0));
        chk("flush_valid", 512'(pr_r_valid), 512'(0));

        for (int i = 0; i < 8; i++) begin
            op(3'd1, c_b + 64'(i) * 64'h40, '0, 1'b0);
            if (i == 5) chk("fill6_afull", 512'(almostFull), 512'(0));
            if (i == 6) chk("fill7_afull", 512'(almostFull), 512'(1));
        end
        chk("full_cnt",  512'(prefetchReqCnt), 512'(8));
        chk("full_perr", 512'(protErr), 512'(0));
        op(3'd1, c_b + 64'h1000, '0, 1'b0);
        chk("ovf_cnt",  512'(prefetchReqCnt), 512'(8));
        chk("ovf_perr", 512'(protErr), 512'(1));

        // Steady-state pop/refill; pointers wrap past 2*DEPTH
        for (int i = 0; i < 20; i++) begin
            op(3'd3, '0, {480'h0, 32'hA500_0000 + 32'(i)}, i[0]);
            master_req(c_b + 64'(i) * 64'h40, 1'b1);
            chk("wrap_valid", 512'(pr_r_valid), 512'(1));
            chk("wrap_data",  pr_r_data, {480'h0, 32'hA500_0000 + 32'(i)});
            chk("wrap_last",  512'(pr_r_last), 512'(i[0]));
            op(3'd4, '0, '0, 1'b0);
            op(3'd1, c_b + 64'(i + 8) * 64'h40, '0, 1'b0);
        end
        chk("wrap_cnt",   512'(prefetchReqCnt), 512'(8));
        chk("wrap_afull", 512'(almostFull), 512'(1));
        chk("wrap_outst", 512'(pr_hasOutstanding), 512'(1));

        op(3'd3, '0, c_d0, 1'b0);
        master_req(c_b + 64'd20 * 64'h40, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("areset_cnt",   512'(prefetchReqCnt), 512'(0));
        chk("areset_valid", 512'(pr_r_valid), 512'(0));
        chk("areset_perr",  512'(protErr), 512'(0));
        chk("areset_afull", 512'(almostFull), 512'(0));
        chk("areset_data",  pr_r_data, 512'(0));
        @(posedge clk); #1 reset = 1'b0;
        chk("post_rst_outst", 512'(pr_hasOutstanding), 512'(0));

        op(3'd6, '0, '0, 1'b0);
        chk("badop_perr", 512'(protErr), 512'(1));
        chk("badop_cnt",  512'(prefetchReqCnt), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
